// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, instruction field
// positions, FSM state encoding and small opcode classification helpers.
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_MULT   = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_AND    = 4'd4;
    localparam logic [3:0] OP_XOR    = 4'd5;
    localparam logic [3:0] OP_LSL    = 4'd6;
    localparam logic [3:0] OP_LSR    = 4'd7;
    localparam logic [3:0] OP_ROR    = 4'd8;
    localparam logic [3:0] OP_CMP    = 4'd9;
    localparam logic [3:0] OP_ILL_LO = 4'd10;
    localparam logic [3:0] OP_ILL_HI = 4'd14;
    localparam logic [3:0] OP_LDI    = 4'd15;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS2_MSB = 7;
    localparam int RS2_LSB = 4;
    localparam int RS3_MSB = 3;
    localparam int RS3_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= OP_ILL_LO) && (op <= OP_ILL_HI);
    endfunction

    function automatic logic uses_alu(input logic [3:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_MULT, OP_OR, OP_AND,
            OP_XOR, OP_LSL, OP_LSR, OP_ROR, OP_CMP: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

    // CMP reuses the ALU subtractor; only the flags are kept.
    function automatic logic [3:0] alu_code(input logic [3:0] op);
        return (op == OP_CMP) ? OP_SUB : op;
    endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// REGS x LEN register file: two operand read ports, one debug read port and a
// single synchronous write port. Macro ALU_CTRL_ZERO_REG_EN makes r0 read as zero.
module alu_ctrl_regfile
    import alu_ctrl_pkg::*;
#(
    parameter int LEN  = 32,
    parameter int REGS = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [3:0]     waddr,
    input  logic [LEN-1:0] wdata,
    input  logic [3:0]     raddr_a,
    input  logic [3:0]     raddr_b,
    input  logic [3:0]     dbg_raddr,
    output logic [LEN-1:0] rdata_a,
    output logic [LEN-1:0] rdata_b,
    output logic [LEN-1:0] dbg_rdata
);

    logic [LEN-1:0] mem_r [REGS];
    logic           we_s;

`ifdef ALU_CTRL_ZERO_REG_EN
    assign we_s      = we && (waddr != 4'd0);
    assign rdata_a   = (raddr_a   == 4'd0) ? {LEN{1'b0}} : mem_r[raddr_a];
    assign rdata_b   = (raddr_b   == 4'd0) ? {LEN{1'b0}} : mem_r[raddr_b];
    assign dbg_rdata = (dbg_raddr == 4'd0) ? {LEN{1'b0}} : mem_r[dbg_raddr];
`else
    assign we_s      = we;
    assign rdata_a   = mem_r[raddr_a];
    assign rdata_b   = mem_r[raddr_b];
    assign dbg_rdata = mem_r[dbg_raddr];
`endif

    // Storage array with single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REGS; i++) begin
                mem_r[i] <= {LEN{1'b0}};
            end
        end else if (we_s) begin
            mem_r[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller driving the combinational ALU: IDLE -> EXEC -> WB sequencing,
// operand fetch, result/flag write-back. Optional macro: ALU_CTRL_ZERO_REG_EN.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int LEN  = 32,
    parameter int REGS = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [15:0]    instr,
    output logic [3:0]     alu_opcode,
    output logic [LEN-1:0] alu_a,
    output logic [LEN-1:0] alu_b,
    input  logic [LEN-1:0] alu_result,
    input  logic [3:0]     alu_flags,
    output logic [3:0]     flags,
    output logic           done,
    output logic           illegal,
    input  logic [3:0]     dbg_raddr,
    output logic [LEN-1:0] dbg_rdata
);

    state_e         state_r;
    logic [3:0]     rd_r;
    logic           no_wb_r;
    logic           ready_r;
    logic           done_r;
    logic           illegal_r;
    logic [3:0]     opcode_r;
    logic [3:0]     flags_r;
    logic [LEN-1:0] a_r;
    logic [LEN-1:0] b_r;

    logic [3:0]     op_s;
    logic [3:0]     rd_s;
    logic [3:0]     rs2_s;
    logic [3:0]     rs3_s;
    logic [7:0]     imm_s;
    logic           accept_s;
    logic           we_s;
    logic [3:0]     waddr_s;
    logic [LEN-1:0] wdata_s;
    logic [LEN-1:0] rdata_a_s;
    logic [LEN-1:0] rdata_b_s;

    assign op_s     = instr[OPC_MSB:OPC_LSB];
    assign rd_s     = instr[RD_MSB:RD_LSB];
    assign rs2_s    = instr[RS2_MSB:RS2_LSB];
    assign rs3_s    = instr[RS3_MSB:RS3_LSB];
    assign imm_s    = instr[IMM_MSB:IMM_LSB];
    assign accept_s = instr_valid && ready_r;

    assign instr_ready = ready_r;
    assign alu_opcode  = opcode_r;
    assign alu_a       = a_r;
    assign alu_b       = b_r;
    assign flags       = flags_r;
    assign done        = done_r;
    assign illegal     = illegal_r;

    // Write-port source select: LDI immediate at acceptance, ALU result at end of EXEC.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = 4'd0;
        wdata_s = {LEN{1'b0}};
        if ((state_r == ST_IDLE) && accept_s && (op_s == OP_LDI)) begin
            we_s    = 1'b1;
            waddr_s = rd_s;
            wdata_s = {{(LEN-8){1'b0}}, imm_s};
        end else if ((state_r == ST_EXEC) && !no_wb_r) begin
            we_s    = 1'b1;
            waddr_s = rd_r;
            wdata_s = alu_result;
        end else begin
            we_s    = 1'b0;
        end
    end

    alu_ctrl_regfile #(
        .LEN  (LEN),
        .REGS (REGS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we        (we_s),
        .waddr     (waddr_s),
        .wdata     (wdata_s),
        .raddr_a   (rs2_s),
        .raddr_b   (rs3_s),
        .dbg_raddr (dbg_raddr),
        .rdata_a   (rdata_a_s),
        .rdata_b   (rdata_b_s),
        .dbg_rdata (dbg_rdata)
    );

    // Sequencing FSM with all handshake, ALU and status outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            rd_r      <= 4'd0;
            no_wb_r   <= 1'b0;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
            opcode_r  <= 4'd0;
            flags_r   <= 4'd0;
            a_r       <= {LEN{1'b0}};
            b_r       <= {LEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r    <= 1'b0;
                    illegal_r <= 1'b0;
                    if (accept_s) begin
                        ready_r <= 1'b0;
                        if (is_illegal(op_s)) begin
                            done_r    <= 1'b1;
                            illegal_r <= 1'b1;
                            state_r   <= ST_WB;
                        end else if (uses_alu(op_s)) begin
                            // Operands captured here, so rd aliasing rs2/rs3 is harmless.
                            opcode_r <= alu_code(op_s);
                            a_r      <= rdata_a_s;
                            b_r      <= rdata_b_s;
                            rd_r     <= rd_s;
                            no_wb_r  <= (op_s == OP_CMP);
                            state_r  <= ST_EXEC;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= ST_WB;
                        end
                    end
                end
                ST_EXEC: begin
                    flags_r <= alu_flags;
                    done_r  <= 1'b1;
                    state_r <= ST_WB;
                end
                ST_WB: begin
                    done_r    <= 1'b0;
                    illegal_r <= 1'b0;
                    ready_r   <= 1'b1;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    done_r    <= 1'b0;
                    illegal_r <= 1'b0;
                    ready_r   <= 1'b1;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed sequence, reset abort, random
// traffic, all checked against an architectural model of the register file.
module tb_alu_issue_ctrl;

    localparam int LEN = 32;

    typedef struct {
        logic        ill;
        logic        chk_alu;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rd;
        logic [31:0] rdval;
        logic [3:0]  flg;
        int          done_cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           instr_valid = 1'b0;
    logic           instr_ready;
    logic [15:0]    instr = 16'h0000;
    logic [3:0]     alu_opcode;
    logic [LEN-1:0] alu_a;
    logic [LEN-1:0] alu_b;
    logic [LEN-1:0] alu_result;
    logic [3:0]     alu_flags;
    logic [3:0]     flags;
    logic           done;
    logic           illegal;
    logic [3:0]     dbg_raddr;
    logic [LEN-1:0] dbg_rdata;

    logic           mon_busy = 1'b0;
    logic [3:0]     mon_addr = 4'd0;
    logic [3:0]     init_addr = 4'd0;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int prev_acc = 0;
    int prev_lat = 0;

    exp_t        exp_q[$];
    logic [31:0] m_rf [16];
    logic [3:0]  m_flags;

    assign dbg_raddr = mon_busy ? mon_addr : init_addr;

    // Environment ALU: shifts and rotate move by one position and ignore b.
    function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        case (op)
            4'd0:    w = {1'b0, a} + {1'b0, b};
            4'd1:    w = {1'b0, a} - {1'b0, b};
            4'd2:    w = {1'b0, a * b};
            4'd3:    w = {1'b0, a | b};
            4'd4:    w = {1'b0, a & b};
            4'd5:    w = {1'b0, a ^ b};
            4'd6:    w = {a, 1'b0};
            4'd7:    w = {1'b0, 1'b0, a[31:1]};
            4'd8:    w = {1'b0, a[0], a[31:1]};
            default: w = 33'd0;
        endcase
        r = w[31:0];
        return {r[31], (r == 32'd0), w[32], ^r, r};
    endfunction

    assign {alu_flags, alu_result} = alu_fn(alu_opcode, alu_a, alu_b);

    alu_issue_ctrl #(.LEN(LEN), .REGS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .flags       (flags),
        .done        (done),
        .illegal     (illegal),
        .dbg_raddr   (dbg_raddr),
        .dbg_rdata   (dbg_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act !== expv) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] mrd(input logic [3:0] i);
`ifdef ALU_CTRL_ZERO_REG_EN
        if (i == 4'd0) return 32'd0;
`endif
        return m_rf[i];
    endfunction

    function automatic void mwr(input logic [3:0] i, input logic [31:0] v);
`ifdef ALU_CTRL_ZERO_REG_EN
        if (i == 4'd0) return;
`endif
        m_rf[i] = v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;
        m_flags = 4'd0;
    endfunction

    // Present a word, wait for acceptance, apply it to the model and queue the expectation.
    task automatic issue(input logic [15:0] w);
        exp_t e;
        int waitc;
        int acc;
        int lat;
        logic held;
        logic [3:0] op;
        logic [3:0] aop;
        logic [35:0] res;
        held = instr_valid;
        instr = w;
        instr_valid = 1'b1;
        waitc = 0;
        while (!instr_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!instr_ready) begin
            check("ready_timeout", 32'd0, 32'd1);
            instr_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        op = w[15:12];
        e.rd = w[11:8];
        e.a = mrd(w[7:4]);
        e.b = mrd(w[3:0]);
        e.ill = 1'b0;
        e.chk_alu = 1'b0;
        e.op = op;
        if (op >= 4'd10 && op <= 4'd14) begin
            e.ill = 1'b1;
            lat = 2;
        end else if (op == 4'd15) begin
            mwr(e.rd, {24'd0, w[7:0]});
            lat = 2;
        end else begin
            aop = (op == 4'd9) ? 4'd1 : op;
            res = alu_fn(aop, e.a, e.b);
            m_flags = res[35:32];
            if (op != 4'd9) mwr(e.rd, res[31:0]);
            e.chk_alu = 1'b1;
            e.op = aop;
            lat = 3;
        end
        e.flg = m_flags;
        e.rdval = mrd(e.rd);
        e.done_cyc = (lat == 3) ? acc + 1 : acc;
        if (held) check("accept_gap", 32'(acc - prev_acc), 32'(prev_lat));
        prev_acc = acc;
        prev_lat = lat;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic reset_checks();
        check("rst_ready", {31'd0, instr_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        check("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        for (int i = 0; i < 16; i++) begin
            init_addr = 4'(i);
            #1;
            check("rst_reg", dbg_rdata, 32'd0);
        end
    endtask

    // Monitor: every done pulse retires the oldest queued expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && illegal && !done) check("illegal_without_done", {31'd0, illegal}, 32'd0);
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("illegal", {31'd0, illegal}, {31'd0, e.ill});
                check("flags", {28'd0, flags}, {28'd0, e.flg});
                check("done_latency", 32'(cyc), 32'(e.done_cyc));
                if (e.chk_alu) begin
                    check("alu_opcode", {28'd0, alu_opcode}, {28'd0, e.op});
                    check("alu_a", alu_a, e.a);
                    check("alu_b", alu_b, e.b);
                end
                mon_busy = 1'b1;
                mon_addr = e.rd;
                #1;
                check("rd_value", dbg_rdata, e.rdval);
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        model_reset();
        #2 rst = 1'b1;
        #25 rst = 1'b0;
        @(negedge clk);
        reset_checks();
        @(negedge clk);

        // Directed: valid held high between words to exercise back-to-back acceptance.
        issue(16'hF105);
        issue(16'hF203);
        issue(16'h0312);
        issue(16'h9711);
        issue(16'hA112);
        issue(16'hF511);
        issue(16'hF0FF);

        // Abort an ADD while it sits in EXEC.
        issue(16'h0412);
        exp_q.delete();
        rst = 1'b1;
        instr_valid = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        reset_checks();
        repeat (3) @(negedge clk);

        // Random traffic with LDI weighted up so registers carry data.
        for (int n = 0; n < 80; n++) begin
            logic [15:0] w;
            int gap;
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[15:12] = 4'hF;
            issue(w);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                instr_valid = 1'b0;
                @(negedge clk);
            end
        end
        instr_valid = 1'b0;

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        if (exp_q.size() != 0) check("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
